// File: rtl/ddc_pkg.sv
// Shared types and width helpers for the DDC decimating boxcar stage.
package ddc_pkg;

    localparam int unsigned DEF_DSIZE = 25;
    localparam int unsigned DEF_WLEN  = 256;

    function automatic int unsigned acc_width(input int unsigned dsize, input int unsigned wlen);
        return dsize + $clog2(wlen);
    endfunction

    // Counters for ranges of one still need a single bit of storage.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic signed [DEF_DSIZE-1:0]                          sample_t;
    typedef logic signed [acc_width(DEF_DSIZE, DEF_WLEN)-1:0]     acc_t;

    typedef enum logic {FILL, RUN} state_t;

endpackage

// File: rtl/boxcar_decim_if.sv
// Sample-in / average-out bundle between the shift register stage and boxcar_decim.
interface boxcar_decim_if #(
    parameter int unsigned DSIZE = 25,
    parameter int unsigned OSIZE = 25
);
    logic signed [DSIZE-1:0] din;
    logic signed [DSIZE-1:0] din_dly;
    logic                    in_valid;
    logic signed [OSIZE-1:0] dout;
    logic                    out_valid;
    logic                    primed;

    modport master (
        output din, din_dly, in_valid,
        input  dout, out_valid, primed
    );

    modport slave (
        input  din, din_dly, in_valid,
        output dout, out_valid, primed
    );
endinterface

// File: rtl/boxcar_scale.sv
// Combinational window-sum to mean conversion: shift by LOG2W, then truncate to OSIZE.
// Define BOXCAR_ROUND_EN for round-half-up instead of floor.
module boxcar_scale #(
    parameter int unsigned AW    = 33,
    parameter int unsigned LOG2W = 8,
    parameter int unsigned OSIZE = 25
) (
    input  logic signed [AW-1:0]    acc,
    output logic signed [OSIZE-1:0] y
);

`ifdef BOXCAR_ROUND_EN
    // One extra bit so the half-LSB bias cannot wrap the most positive sum.
    localparam logic signed [AW:0] HALF = (AW+1)'(1) << (LOG2W-1);

    logic signed [AW:0] biased;

    always_comb begin
        biased = $signed({acc[AW-1], acc}) + HALF;
        y      = OSIZE'(biased >>> LOG2W);
    end
`else
    always_comb begin
        y = OSIZE'(acc >>> LOG2W);
    end
`endif

endmodule

// File: rtl/boxcar_decim.sv
// Decimating moving-average stage fed by the RAM shift register (din and its WLEN-delayed copy).
// Optional macro BOXCAR_ROUND_EN selects rounding in boxcar_scale.
module boxcar_decim
    import ddc_pkg::*;
#(
    parameter int unsigned DSIZE = 25,
    parameter int unsigned WLEN  = 256,
    parameter int unsigned LOG2W = $clog2(WLEN),
    parameter int unsigned DECIM = 16,
    parameter int unsigned OSIZE = 25
) (
    input  logic           clk,
    input  logic           Reset,
    boxcar_decim_if.slave  bus
);

    localparam int unsigned AW  = acc_width(DSIZE, WLEN);
    localparam int unsigned DCW = cnt_width(DECIM);

    if (OSIZE < DSIZE) begin : g_osize_low
        $error("boxcar_decim: OSIZE must be at least DSIZE");
    end
    if (OSIZE > AW) begin : g_osize_high
        $error("boxcar_decim: OSIZE must not exceed DSIZE+LOG2W");
    end
    if (WLEN < 2 || (WLEN & (WLEN - 1)) != 0) begin : g_wlen_pow2
        $error("boxcar_decim: WLEN must be a power of two >= 2");
    end
    if (DECIM < 1 || DECIM > 65535) begin : g_decim_range
        $error("boxcar_decim: DECIM out of range 1..65535");
    end

    state_t                 state;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   add_op;
    logic signed [AW-1:0]   sub_op;
    logic [LOG2W-1:0]       fill_cnt;
    logic [DCW-1:0]         dec_cnt;
    logic                   fill_last;
    logic                   run_next;
    logic                   dec_last;
    logic signed [OSIZE-1:0] scaled;

    // The delayed operand is RAM garbage until the window has filled once.
    always_comb begin
        add_op    = {{LOG2W{bus.din[DSIZE-1]}}, bus.din};
        sub_op    = (state == RUN) ? {{LOG2W{bus.din_dly[DSIZE-1]}}, bus.din_dly} : '0;
        acc_next  = bus.in_valid ? (acc + add_op - sub_op) : acc;
        fill_last = (state == FILL) && (fill_cnt == LOG2W'(WLEN - 1));
        run_next  = (state == RUN) || (bus.in_valid && fill_last);
        dec_last  = (dec_cnt == DCW'(DECIM - 1));
    end

    boxcar_scale #(
        .AW    (AW),
        .LOG2W (LOG2W),
        .OSIZE (OSIZE)
    ) u_scale (
        .acc (acc_next),
        .y   (scaled)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state         <= FILL;
            acc           <= '0;
            fill_cnt      <= '0;
            dec_cnt       <= '0;
            bus.dout      <= '0;
            bus.out_valid <= 1'b0;
            bus.primed    <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid) begin
                acc     <= acc_next;
                dec_cnt <= dec_last ? '0 : dec_cnt + DCW'(1);
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + LOG2W'(1);
                        if (fill_last) begin
                            state      <= RUN;
                            bus.primed <= 1'b1;
                        end
                    end
                    RUN: begin
                    end
                endcase
                // The fill-completing sample may already emit if the decimator lines up.
                if (dec_last && run_next) begin
                    bus.dout      <= scaled;
                    bus.out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boxcar_decim.sv
// Directed bench for boxcar_decim with WLEN=8; a DECIM=4 and a DECIM=1 instance share the stimulus.
module tb_boxcar_decim;

    logic clk;
    logic Reset;

    boxcar_decim_if #(.DSIZE(25), .OSIZE(25)) bus  ();
    boxcar_decim_if #(.DSIZE(25), .OSIZE(25)) bus1 ();

    boxcar_decim #(
        .DSIZE (25),
        .WLEN  (8),
        .DECIM (4),
        .OSIZE (25)
    ) u_dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    boxcar_decim #(
        .DSIZE (25),
        .WLEN  (8),
        .DECIM (1),
        .OSIZE (25)
    ) u_d1 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int kk     = 0;
    int hcnt   = 0;
    int hist[8];
    int exp_d  = 0;
    int exp_d1 = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_val);
        total++;
        assert (obs === exp_val) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_val);
    endtask

    // Models the shift register: Q is the sample pushed WLEN valid strobes earlier, never reset.
    task automatic drive(input int d, input bit v);
        int dly;
        dly = (hcnt >= 8) ? hist[hcnt % 8] : int'($urandom);
        bus.din       = 25'(d);
        bus.din_dly   = 25'(dly);
        bus.in_valid  = v;
        bus1.din      = 25'(d);
        bus1.din_dly  = 25'(dly);
        bus1.in_valid = v;
        @(posedge clk);
        if (v) begin
            hist[hcnt % 8] = d;
            hcnt++;
        end
        #1;
    endtask

    task automatic sample(input int d, input int mean, input bit check1);
        bit ev;
        bit ev1;
        drive(d, 1'b1);
        ev  = (kk >= 7) && (kk % 4 == 3);
        ev1 = (kk >= 7);
        if (ev)  exp_d  = mean;
        if (ev1) exp_d1 = mean;
        kk++;
        chk("out_valid", bus.out_valid, ev);
        chk("dout",      bus.dout,      exp_d);
        chk("primed",    bus.primed,    kk >= 8);
        if (check1) begin
            chk("d1_out_valid", bus1.out_valid, ev1);
            chk("d1_dout",      bus1.dout,      exp_d1);
            chk("d1_primed",    bus1.primed,    kk >= 8);
        end
    endtask

    task automatic idle();
        drive(int'($urandom), 1'b0);
        chk("gap_out_valid", bus.out_valid, 1'b0);
        chk("gap_dout",      bus.dout,      exp_d);
        chk("gap_primed",    bus.primed,    kk >= 8);
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        Reset  = 1'b0;
        kk     = 0;
        exp_d  = 0;
        exp_d1 = 0;
        chk("rst_out_valid",    bus.out_valid,  1'b0);
        chk("rst_dout",         bus.dout,       0);
        chk("rst_primed",       bus.primed,     1'b0);
        chk("rst_d1_out_valid", bus1.out_valid, 1'b0);
        chk("rst_d1_dout",      bus1.dout,      0);
        chk("rst_d1_primed",    bus1.primed,    1'b0);
    endtask

    initial begin
        Reset         = 1'b1;
        bus.din       = '0;
        bus.din_dly   = '0;
        bus.in_valid  = 1'b0;
        bus1.din      = '0;
        bus1.din_dly  = '0;
        bus1.in_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Constant 1000: first output on the 8th sample, then every 4.
        do_reset();
        for (int k = 0; k < 16; k++) sample(1000, 1000, 1'b0);

        // Ramp din=n: mean of n-7..n is n-3.5.
        do_reset();
        for (int k = 0; k < 24; k++) begin
`ifdef BOXCAR_ROUND_EN
            sample(k, k - 3, 1'b0);
`else
            sample(k, k - 4, 1'b0);
`endif
        end

        // Full-scale extremes.
        do_reset();
        for (int k = 0; k < 12; k++) sample(16777215, 16777215, 1'b0);
        do_reset();
        for (int k = 0; k < 12; k++) sample(-16777216, -16777216, 1'b0);

        // One valid every three clocks.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            sample(-1000, -1000, 1'b0);
            idle();
            idle();
        end

        // Single-cycle reset while running; window must refill with fresh data only.
        do_reset();
        for (int k = 0; k < 12; k++) sample(50, 50, 1'b0);

        // DECIM=1 instance emits on every sample once primed.
        do_reset();
        for (int k = 0; k < 12; k++) sample(7, 7, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
